// File: rtl/booth_pkg.sv
// Shared constants, action codes and FSM states for the Booth MAC.
// Latency: n/a (declarations and a pure recoding function only).
// Backpressure: n/a.
package booth_pkg;

    localparam int OPW  = 8;
    localparam int ADW  = 16;
    localparam int RESW = 17;
    localparam int PPW  = 10;

    localparam logic [2:0] ACT_ZERO = 3'd0;
    localparam logic [2:0] ACT_POS1 = 3'd1;
    localparam logic [2:0] ACT_POS2 = 3'd2;
    localparam logic [2:0] ACT_NEG1 = 3'd3;
    localparam logic [2:0] ACT_NEG2 = 3'd4;
    localparam logic [2:0] ACT_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Radix-4 Booth recoding of one overlapping multiplier triplet.
    function automatic logic [2:0] booth_encode(input logic [2:0] trip);
        logic [2:0] code;
        case (trip)
            3'b000, 3'b111: code = ACT_ZERO;
            3'b001, 3'b010: code = ACT_POS1;
            3'b011:         code = ACT_POS2;
            3'b100:         code = ACT_NEG2;
            default:        code = ACT_NEG1;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Selects the signed partial product (0, +-M, +-2M) for one Booth action code.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module booth_pp_select
    import booth_pkg::*;
(
    input  logic [2:0]              action,
    input  logic signed [OPW-1:0]   multiplicand,
    output logic signed [PPW-1:0]   pp
);

    logic signed [PPW-1:0] w_m1;
    logic signed [PPW-1:0] w_m2;

    // 10 bits hold +-2*(-128) = +-256 without overflow.
    assign w_m1 = {{2{multiplicand[OPW-1]}}, multiplicand};
    assign w_m2 = {multiplicand[OPW-1], multiplicand, 1'b0};

    // Action code to partial product; reserved and unused codes give zero.
    always_comb begin
        pp = '0;
        case (action)
            ACT_POS1: pp = w_m1;
            ACT_POS2: pp = w_m2;
            ACT_NEG1: pp = -w_m1;
            ACT_NEG2: pp = -w_m2;
            default:  pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mac_seq.sv
// Sequential radix-4 Booth MAC: result = M*B + C, one Booth digit per RUN cycle.
// Latency: done pulses 5 cycles after the accepting edge; one op per 5 cycles back-to-back.
// Backpressure: start is ignored while busy; operands are captured only on accept.
module booth_mac_seq
    import booth_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [OPW-1:0]   multiplicand,
    input  logic signed [OPW-1:0]   multiplier,
    input  logic signed [ADW-1:0]   addend,
    output logic                    busy,
    output logic                    done,
    output logic signed [RESW-1:0]  result,
    output logic [2:0]              pp_action
);

    state_t                 r_state;
    logic [1:0]             r_step;
    logic signed [OPW-1:0]  r_m;
    logic signed [OPW-1:0]  r_b;
    logic signed [RESW-1:0] r_acc;
    logic signed [RESW-1:0] r_result;

    logic [2:0]             w_trip;
    logic signed [PPW-1:0]  w_pp;
    logic signed [RESW-1:0] w_pp_ext;
    logic signed [RESW-1:0] w_pp_sh;
    logic signed [RESW-1:0] w_acc_nxt;

    // Overlapping triplet {B[2i+1], B[2i], B[2i-1]} for the current step, B[-1] = 0.
    always_comb begin
        w_trip = 3'b000;
        case (r_step)
            2'd0: w_trip = {r_b[1:0], 1'b0};
            2'd1: w_trip = r_b[3:1];
            2'd2: w_trip = r_b[5:3];
            2'd3: w_trip = r_b[7:5];
            default: w_trip = 3'b000;
        endcase
    end

    assign pp_action = (r_state == ST_RUN) ? booth_encode(w_trip) : ACT_ZERO;

    booth_pp_select u_pp_select (
        .action       (pp_action),
        .multiplicand (r_m),
        .pp           (w_pp)
    );

    // Digit weight is 4^step, i.e. a left shift by 2*step.
    assign w_pp_ext  = {{(RESW-PPW){w_pp[PPW-1]}}, w_pp};
    assign w_pp_sh   = w_pp_ext << {r_step, 1'b0};
    assign w_acc_nxt = r_acc + w_pp_sh;

    // FSM, operand capture, step counter and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_step   <= 2'd0;
            r_m      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_m     <= multiplicand;
                        r_b     <= multiplier;
                        r_acc   <= {addend[ADW-1], addend};
                        r_step  <= 2'd0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc  <= w_acc_nxt;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        // Only the final sum is published; partial sums stay internal.
                        r_result <= w_acc_nxt;
                        r_state  <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == ST_RUN);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_booth_mac_seq.sv
// Scoreboard bench for booth_mac_seq: stimulus pushes expected ops, monitor checks every cycle.
// Latency: expects done 4 edges after the accepting edge (5th cycle), busy for the 4 cycles before.
// Backpressure: starts issued while the model says busy must be ignored.
module tb_booth_mac_seq;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [7:0]  multiplicand;
    logic signed [7:0]  multiplier;
    logic signed [15:0] addend;
    logic               busy;
    logic               done;
    logic signed [16:0] result;
    logic [2:0]         pp_action;

    booth_mac_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .pp_action    (pp_action)
    );

    typedef struct {
        int b;
        int res;
        int acc_edge;
    } entry_t;

    entry_t sb_q[$];
    int     checks   = 0;
    int     errors   = 0;
    int     edge_cnt = 0;
    int     next_ok  = 0;
    int     accepts  = 0;
    int     exp_res  = 0;
    bit     mon_en   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_cnt, act, exp);
        end
    endtask

    // Booth digit i of B is -2*B[2i+1] + B[2i] + B[2i-1]; map digit value to its action code.
    function automatic int code_of(input int b, input int i);
        int bb;
        int d;
        bb = b & 255;
        d  = -2 * ((bb >> (2*i + 1)) & 1) + ((bb >> (2*i)) & 1);
        if (i > 0) d += (bb >> (2*i - 1)) & 1;
        case (d)
            1:  return 1;
            2:  return 2;
            -1: return 3;
            -2: return 4;
            default: return 0;
        endcase
    endfunction

    // One clock: drive inputs, pass the edge, then update the model for that edge.
    task automatic cyc(input logic st, input int m, input int b, input int c,
                       input logic r, input logic ov, input int ov_val);
        entry_t e;
        start        = st;
        multiplicand = 8'(m);
        multiplier   = 8'(b);
        addend       = 16'(c);
        rst          = r;
        @(posedge clk);
        #1;
        edge_cnt++;
        if (r) begin
            sb_q.delete();
            exp_res = 0;
            next_ok = edge_cnt + 1;
            mon_en  = 1'b1;
        end else if (st && edge_cnt >= next_ok) begin
            e.b        = b;
            e.res      = ov ? ov_val : (m * b + c);
            e.acc_edge = edge_cnt;
            sb_q.push_back(e);
            next_ok = edge_cnt + 5;
            accepts++;
        end
        @(negedge clk);
    endtask

    task automatic op(input int m, input int b, input int c, input int exp);
        cyc(1'b1, m, b, c, 1'b0, 1'b1, exp);
        repeat (5) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    // Monitor: derive expected busy/done/result/pp_action from the oldest in-flight op.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                bit have;
                int d;
                int e_busy;
                int e_done;
                int e_pp;
                have   = (sb_q.size() > 0);
                d      = have ? (edge_cnt - sb_q[0].acc_edge) : -1;
                e_busy = (have && d >= 0 && d <= 3) ? 1 : 0;
                e_done = (have && d == 4) ? 1 : 0;
                e_pp   = e_busy ? code_of(sb_q[0].b, d) : 0;
                if (have && d > 4) begin
                    check("done_timeout", 0, 1);
                    void'(sb_q.pop_front());
                end
                if (e_done) begin
                    exp_res = sb_q[0].res;
                    void'(sb_q.pop_front());
                end
                check("busy", int'(busy), e_busy);
                check("done", int'(done), e_done);
                check("pp_action", int'(pp_action), e_pp);
                check("result", int'(result), exp_res);
            end
        end
    end

    initial begin
        int guard;
        int target;
        logic st;
        logic r;
        rst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        addend = '0;

        repeat (2) cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
        repeat (2) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);

        // Hand-computed cases.
        op(3, 5, 0, 15);
        op(-128, -128, 0, 16384);
        op(-128, 127, -32768, -49024);
        op(1, 8'h6C, 0, 108);

        // start held high: second op accepted in DONE, busy-time starts ignored.
        cyc(1'b1, 2, 2, 1, 1'b0, 1'b1, 5);
        repeat (5) cyc(1'b1, -7, 9, 100, 1'b0, 1'b1, 37);
        repeat (6) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);

        // Reset in the third RUN cycle aborts without done, then a fresh op completes.
        cyc(1'b1, 5, 6, 7, 1'b0, 1'b0, 0);
        repeat (2) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
        repeat (6) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        op(4, -3, 10, -2);

        // Randomized ops with random start gaps, operand churn and rare resets.
        target = accepts + 10000;
        guard  = 0;
        while (accepts < target && guard < 60000) begin
            st = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 1999) == 0);
            cyc(st, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 65535)) - 32768, r, 1'b0, 0);
            guard++;
        end
        check("random_ops_issued", (accepts >= target) ? 1 : 0, 1);

        repeat (8) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
